// File: rtl/confreg_pkg.sv
// Shared definitions for the configuration-register window: register offsets,
// timer control bit positions, access kinds and the byte-lane write merge.
package confreg_pkg;

   localparam logic [15:0] CR0_OFF        = 16'h8000;
   localparam logic [15:0] CR1_OFF        = 16'h8004;
   localparam logic [15:0] CR2_OFF        = 16'h8008;
   localparam logic [15:0] CR3_OFF        = 16'h800C;
   localparam logic [15:0] TIMER_OFF      = 16'hE000;
   localparam logic [15:0] TIMER_CMP_OFF  = 16'hE004;
   localparam logic [15:0] TIMER_CTRL_OFF = 16'hE008;
   localparam logic [15:0] LED_OFF        = 16'hF000;
   localparam logic [15:0] LED_RG0_OFF    = 16'hF004;
   localparam logic [15:0] LED_RG1_OFF    = 16'hF008;
   localparam logic [15:0] NUM_OFF        = 16'hF010;
   localparam logic [15:0] SWITCH_OFF     = 16'hF020;
   localparam logic [15:0] BTN_KEY_OFF    = 16'hF024;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_PEND_BIT = 1;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_READ,
      ACC_WRITE
   } access_e;

   // Each enabled byte lane takes the new data; the others keep the old value.
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  wen);
      logic [31:0] result;
      for (int i = 0; i < 4; i++) begin
         result[i*8 +: 8] = wen[i] ? newVal[i*8 +: 8] : oldVal[i*8 +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running 32-bit timer with compare register, enable bit and a sticky
// pending flag that drives the external interrupt.
module confreg_timer
   import confreg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_timerWe,
   input  logic        i_cmpWe,
   input  logic        i_ctrlWe,
   input  logic [3:0]  i_wen,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_timer,
   output logic [31:0] o_cmp,
   output logic [31:0] o_ctrl,
   output logic        o_irq
);

   logic [31:0] r_timer;
   logic [31:0] r_cmp;
   logic        r_enable;
   logic        r_pending;
   logic        w_match;
   logic        w_clear;

   assign w_match = r_enable && (r_timer == r_cmp);
   assign w_clear = i_ctrlWe && i_wen[0] && i_wdata[CTRL_PEND_BIT];

   // A software load of the counter wins over the increment; a match wins over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer   <= '0;
         r_cmp     <= '0;
         r_enable  <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (i_timerWe) begin
            r_timer <= mergeBytes(r_timer, i_wdata, i_wen);
         end else if (r_enable) begin
            r_timer <= r_timer + 32'd1;
         end
         if (i_cmpWe) begin
            r_cmp <= mergeBytes(r_cmp, i_wdata, i_wen);
         end
         if (i_ctrlWe && i_wen[0]) begin
            r_enable <= i_wdata[CTRL_EN_BIT];
         end
         if (w_match) begin
            r_pending <= 1'b1;
         end else if (w_clear) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      o_ctrl                = '0;
      o_ctrl[CTRL_EN_BIT]   = r_enable;
      o_ctrl[CTRL_PEND_BIT] = r_pending;
   end

   assign o_timer = r_timer;
   assign o_cmp   = r_cmp;
   assign o_irq   = r_pending;

endmodule

// File: rtl/sram_confreg.sv
// Board configuration-register window on the data-SRAM port: scratch, LED and
// number outputs, synchronised switch/button inputs and the compare timer.
module sram_confreg
   import confreg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
   parameter int          LED_W     = 16,
   parameter int          SW_W      = 8,
   parameter int          BTN_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_sram_en,
   input  logic [3:0]       data_sram_wen,
   input  logic [31:0]      data_sram_addr,
   input  logic [31:0]      data_sram_wdata,
   output logic [31:0]      data_sram_rdata,
   input  logic [SW_W-1:0]  switch_i,
   input  logic [BTN_W-1:0] btn_key_i,
   output logic [LED_W-1:0] led_o,
   output logic [1:0]       led_rg0_o,
   output logic [1:0]       led_rg1_o,
   output logic [31:0]      num_o,
   output logic             timer_irq_o
);

   logic [31:0]      r_cr [4];
   logic [LED_W-1:0] r_led;
   logic [1:0]       r_rg0;
   logic [1:0]       r_rg1;
   logic [31:0]      r_num;
   logic [SW_W-1:0]  r_swMeta;
   logic [SW_W-1:0]  r_swSync;
   logic [BTN_W-1:0] r_btnMeta;
   logic [BTN_W-1:0] r_btnSync;
   logic [31:0]      r_rdata;

   logic        w_hit;
   access_e     w_access;
   logic [15:0] w_off;
   logic        w_wr;
   logic        w_timerWe;
   logic        w_cmpWe;
   logic        w_ctrlWe;
   logic [31:0] w_timer;
   logic [31:0] w_cmp;
   logic [31:0] w_ctrl;
   logic        w_irq;
   logic [31:0] w_ledMerged;
   logic [31:0] w_rdNext;
   logic        w_unused;

   assign w_hit = data_sram_en && (data_sram_addr[31:16] == BASE_ADDR[31:16]);
   assign w_off = {data_sram_addr[15:2], 2'b00};

   always_comb begin
      w_access = ACC_IDLE;
      if (w_hit) begin
         w_access = (data_sram_wen == 4'b0000) ? ACC_READ : ACC_WRITE;
      end
   end

   assign w_wr      = (w_access == ACC_WRITE);
   assign w_timerWe = w_wr && (w_off == TIMER_OFF);
   assign w_cmpWe   = w_wr && (w_off == TIMER_CMP_OFF);
   assign w_ctrlWe  = w_wr && (w_off == TIMER_CTRL_OFF);

   confreg_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_timerWe (w_timerWe),
      .i_cmpWe   (w_cmpWe),
      .i_ctrlWe  (w_ctrlWe),
      .i_wen     (data_sram_wen),
      .i_wdata   (data_sram_wdata),
      .o_timer   (w_timer),
      .o_cmp     (w_cmp),
      .o_ctrl    (w_ctrl),
      .o_irq     (w_irq)
   );

   // Narrow registers merge at full width and keep only their own lanes.
   assign w_ledMerged = mergeBytes({{(32-LED_W){1'b0}}, r_led}, data_sram_wdata, data_sram_wen);
   assign w_unused    = ^{data_sram_addr[1:0], w_ledMerged[31:LED_W]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_cr[i] <= '0;
         end
         r_led <= '0;
         r_rg0 <= '0;
         r_rg1 <= '0;
         r_num <= '0;
      end else if (w_wr) begin
         case (w_off)
            CR0_OFF, CR1_OFF, CR2_OFF, CR3_OFF:
               r_cr[w_off[3:2]] <= mergeBytes(r_cr[w_off[3:2]], data_sram_wdata, data_sram_wen);
            LED_OFF:
               r_led <= w_ledMerged[LED_W-1:0];
            LED_RG0_OFF:
               if (data_sram_wen[0]) r_rg0 <= data_sram_wdata[1:0];
            LED_RG1_OFF:
               if (data_sram_wen[0]) r_rg1 <= data_sram_wdata[1:0];
            NUM_OFF:
               r_num <= mergeBytes(r_num, data_sram_wdata, data_sram_wen);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_swMeta  <= '0;
         r_swSync  <= '0;
         r_btnMeta <= '0;
         r_btnSync <= '0;
      end else begin
         r_swMeta  <= switch_i;
         r_swSync  <= r_swMeta;
         r_btnMeta <= btn_key_i;
         r_btnSync <= r_btnMeta;
      end
   end

   always_comb begin
      w_rdNext = '0;
      case (w_off)
         CR0_OFF, CR1_OFF, CR2_OFF, CR3_OFF: w_rdNext = r_cr[w_off[3:2]];
         TIMER_OFF:      w_rdNext = w_timer;
         TIMER_CMP_OFF:  w_rdNext = w_cmp;
         TIMER_CTRL_OFF: w_rdNext = w_ctrl;
         LED_OFF:        w_rdNext = {{(32-LED_W){1'b0}}, r_led};
         LED_RG0_OFF:    w_rdNext = {30'd0, r_rg0};
         LED_RG1_OFF:    w_rdNext = {30'd0, r_rg1};
         NUM_OFF:        w_rdNext = r_num;
         SWITCH_OFF:     w_rdNext = {{(32-SW_W){1'b0}}, r_swSync};
         BTN_KEY_OFF:    w_rdNext = {{(32-BTN_W){1'b0}}, r_btnSync};
         default:        w_rdNext = '0;
      endcase
   end

   // Read data only moves on a read hit; writes, misses and idle cycles hold it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_access == ACC_READ) begin
         r_rdata <= w_rdNext;
      end
   end

   assign data_sram_rdata = r_rdata;
   assign led_o           = r_led;
   assign led_rg0_o       = r_rg0;
   assign led_rg1_o       = r_rg1;
   assign num_o           = r_num;
   assign timer_irq_o     = w_irq;

endmodule

// File: tb/tb_sram_confreg.sv
// Directed bench for sram_confreg with a register-map model checked every cycle
// and hand-computed expectations at the interesting points.
module tb_sram_confreg;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch_i;
   logic [15:0] btn_key_i;
   logic [15:0] led_o;
   logic [1:0]  led_rg0_o;
   logic [1:0]  led_rg1_o;
   logic [31:0] num_o;
   logic        timer_irq_o;

   int vecCount  = 0;
   int missCount = 0;

   // Model state: what the register window must hold after each clock edge.
   logic [31:0] mCr [4];
   logic [31:0] mLed, mRg0, mRg1, mNum, mTimer, mCmp, mRdata, mSw1, mSw2, mBtn1, mBtn2;
   logic        mEn, mPend;

   always #5 clk = ~clk;

   sram_confreg dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch_i        (switch_i),
      .btn_key_i       (btn_key_i),
      .led_o           (led_o),
      .led_rg0_o       (led_rg0_o),
      .led_rg1_o       (led_rg1_o),
      .num_o           (num_o),
      .timer_irq_o     (timer_irq_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] blend(input logic [31:0] oldVal, input logic [3:0] wen,
                                         input logic [31:0] newVal, input logic [31:0] widthMask);
      logic [31:0] laneMask;
      laneMask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
      return ((oldVal & ~laneMask) | (newVal & laneMask)) & widthMask;
   endfunction

   function automatic logic [31:0] modelRead(input logic [15:0] off);
      case (off)
         16'h8000: return mCr[0];
         16'h8004: return mCr[1];
         16'h8008: return mCr[2];
         16'h800C: return mCr[3];
         16'hE000: return mTimer;
         16'hE004: return mCmp;
         16'hE008: return {30'd0, mPend, mEn};
         16'hF000: return mLed;
         16'hF004: return mRg0;
         16'hF008: return mRg1;
         16'hF010: return mNum;
         16'hF020: return mSw2;
         16'hF024: return mBtn2;
         default:  return 32'd0;
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mCr[i] = '0;
      mLed = '0; mRg0 = '0; mRg1 = '0; mNum = '0; mTimer = '0; mCmp = '0;
      mRdata = '0; mSw1 = '0; mSw2 = '0; mBtn1 = '0; mBtn2 = '0; mEn = 1'b0; mPend = 1'b0;
   endtask

   // One clock edge of the register window, computed from the pre-edge model state.
   task automatic modelStep();
      logic        hit, match, clr;
      logic [15:0] off;
      logic [31:0] nextTimer;
      hit       = data_sram_en && (data_sram_addr[31:16] == 16'hBFAF);
      off       = {data_sram_addr[15:2], 2'b00};
      match     = mEn && (mTimer == mCmp);
      clr       = 1'b0;
      nextTimer = mEn ? mTimer + 32'd1 : mTimer;
      if (hit && data_sram_wen == 4'b0000) mRdata = modelRead(off);
      if (hit && data_sram_wen != 4'b0000) begin
         case (off)
            16'h8000, 16'h8004, 16'h8008, 16'h800C:
               mCr[off[3:2]] = blend(mCr[off[3:2]], data_sram_wen, data_sram_wdata, 32'hFFFF_FFFF);
            16'hE000: nextTimer = blend(mTimer, data_sram_wen, data_sram_wdata, 32'hFFFF_FFFF);
            16'hE004: mCmp = blend(mCmp, data_sram_wen, data_sram_wdata, 32'hFFFF_FFFF);
            16'hE008: if (data_sram_wen[0]) begin
                         mEn = data_sram_wdata[0];
                         clr = data_sram_wdata[1];
                      end
            16'hF000: mLed = blend(mLed, data_sram_wen, data_sram_wdata, 32'h0000_FFFF);
            16'hF004: mRg0 = blend(mRg0, data_sram_wen, data_sram_wdata, 32'h0000_0003);
            16'hF008: mRg1 = blend(mRg1, data_sram_wen, data_sram_wdata, 32'h0000_0003);
            16'hF010: mNum = blend(mNum, data_sram_wen, data_sram_wdata, 32'hFFFF_FFFF);
            default: ;
         endcase
      end
      mTimer = nextTimer;
      mPend  = match | (mPend & ~clr);
      mSw2   = mSw1;
      mSw1   = {24'd0, switch_i};
      mBtn2  = mBtn1;
      mBtn1  = {16'd0, btn_key_i};
   endtask

   // Drive one access for exactly one clock edge; return at edge + 1 time unit.
   task automatic applyStimulus(input logic en, input logic [3:0] wen,
                                input logic [31:0] addr, input logic [31:0] wdata);
      data_sram_en    = en;
      data_sram_wen   = wen;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      @(posedge clk);
      modelStep();
      #1;
      data_sram_en  = 1'b0;
      data_sram_wen = 4'b0000;
   endtask

   task automatic wr(input logic [15:0] off, input logic [3:0] wen, input logic [31:0] data);
      applyStimulus(1'b1, wen, {16'hBFAF, off}, data);
   endtask

   task automatic rd(input logic [15:0] off);
      applyStimulus(1'b1, 4'b0000, {16'hBFAF, off}, 32'd0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0);
   endtask

   // Every output against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("rdata", data_sram_rdata, mRdata);
         checkOutput("led", {16'd0, led_o}, mLed);
         checkOutput("rg0", {30'd0, led_rg0_o}, mRg0);
         checkOutput("rg1", {30'd0, led_rg1_o}, mRg1);
         checkOutput("num", num_o, mNum);
         checkOutput("irq", {31'd0, timer_irq_o}, {31'd0, mPend});
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vecCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int riseAt;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = 32'd0;
      data_sram_wdata = 32'd0;
      switch_i        = 8'd0;
      btn_key_i       = 16'd0;
      rst             = 1'b0;
      modelReset();
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      rd(16'hF000);
      checkOutput("resetLedRead", data_sram_rdata, 32'h0);
      checkOutput("resetIrq", {31'd0, timer_irq_o}, 32'h0);

      wr(16'h8004, 4'b0101, 32'hAABB_CCDD);
      rd(16'h8004);
      checkOutput("cr1PartialWrite", data_sram_rdata, 32'h00BB_00DD);
      applyStimulus(1'b1, 4'b0000, 32'hBFAF_8007, 32'd0);
      checkOutput("cr1LowAddrIgnored", data_sram_rdata, 32'h00BB_00DD);

      wr(16'hF000, 4'b1111, 32'h0000_1234);
      applyStimulus(1'b1, 4'b0000, 32'hBFBF_F000, 32'd0);
      checkOutput("missHoldsRdata", data_sram_rdata, 32'h00BB_00DD);
      checkOutput("ledValue", {16'd0, led_o}, 32'h0000_1234);
      wr(16'hF000, 4'b0110, 32'h00CC_AB00);
      checkOutput("ledLaneMerge", {16'd0, led_o}, 32'h0000_AB34);
      wr(16'hF004, 4'b1111, 32'hFFFF_FFFF);
      checkOutput("rg0Truncate", {30'd0, led_rg0_o}, 32'h3);
      wr(16'hF008, 4'b0001, 32'h0000_0002);
      wr(16'hF010, 4'b1100, 32'h1234_5678);
      checkOutput("numUpperLanes", num_o, 32'h1234_0000);

      switch_i = 8'h5A;
      rd(16'hF020);
      checkOutput("switchFirstEdgeOld", data_sram_rdata, 32'h0);
      rd(16'hF020);
      rd(16'hF020);
      checkOutput("switchSynced", data_sram_rdata, 32'h0000_005A);
      rd(16'h8010);
      checkOutput("unmappedReadZero", data_sram_rdata, 32'h0);
      wr(16'hF020, 4'b1111, 32'hFFFF_FFFF);
      rd(16'hF020);
      checkOutput("switchReadOnly", data_sram_rdata, 32'h0000_005A);
      btn_key_i = 16'hA5C3;
      idle();
      idle();
      rd(16'hF024);
      checkOutput("btnSynced", data_sram_rdata, 32'h0000_A5C3);

      wr(16'hE004, 4'b1111, 32'h10);
      wr(16'hE000, 4'b1111, 32'h0);
      wr(16'hE008, 4'b0001, 32'h1);
      riseAt = 0;
      for (int i = 1; i <= 40 && riseAt == 0; i++) begin
         idle();
         if (timer_irq_o) riseAt = i;
      end
      checkOutput("irqRiseEdge", riseAt, 32'd17);
      rd(16'hE008);
      checkOutput("ctrlReadback", data_sram_rdata, 32'h3);
      wr(16'hE008, 4'b0001, 32'h2);
      checkOutput("irqCleared", {31'd0, timer_irq_o}, 32'h0);

      wr(16'hE004, 4'b1111, 32'h30);
      wr(16'hE000, 4'b1111, 32'h2E);
      wr(16'hE008, 4'b0001, 32'h1);
      idle();
      idle();
      wr(16'hE008, 4'b0001, 32'h3);
      checkOutput("setBeatsClear", {31'd0, timer_irq_o}, 32'h1);
      wr(16'hE008, 4'b0001, 32'h3);
      checkOutput("clearAfterMatch", {31'd0, timer_irq_o}, 32'h0);

      wr(16'hE000, 4'b1111, 32'hFFFF_FFFF);
      idle();
      rd(16'hE000);
      checkOutput("timerWrap", data_sram_rdata, 32'h0);
      wr(16'hE000, 4'b1111, 32'h7);
      rd(16'hE000);
      checkOutput("timerWriteWins", data_sram_rdata, 32'h7);

      wr(16'hE000, 4'b1111, 32'h2F);
      idle();
      idle();
      idle();
      checkOutput("irqBeforeReset", {31'd0, timer_irq_o}, 32'h1);
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'b1111;
      data_sram_addr  = 32'hBFAF_8000;
      data_sram_wdata = 32'hDEAD_BEEF;
      #3 rst = 1'b1;
      modelReset();
      #1;
      checkOutput("rstIrq", {31'd0, timer_irq_o}, 32'h0);
      checkOutput("rstRdata", data_sram_rdata, 32'h0);
      checkOutput("rstLed", {16'd0, led_o}, 32'h0);
      data_sram_en  = 1'b0;
      data_sram_wen = 4'b0000;
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      rd(16'hE000);
      checkOutput("rstTimerZero", data_sram_rdata, 32'h0);
      rd(16'h8000);
      checkOutput("rstAbortedWrite", data_sram_rdata, 32'h0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
